// File: rtl/acca_pkg.sv
// Shared constants and helpers for the ACCA quadrant-decomposed approximate multiplier.
package acca_pkg;

    localparam int MODE_LL = 0;
    localparam int MODE_LH = 1;
    localparam int MODE_HL = 2;
    localparam int MODE_HH = 3;

    localparam int MASK_MAX = 128;

    // Keeps bits [width-1:trunc]; bits at or above width are always zero.
    function automatic logic [MASK_MAX-1:0] truncMask(input int width, input int trunc);
        logic [MASK_MAX-1:0] m;
        m = '0;
        for (int i = 0; i < MASK_MAX; i++) begin
            m[i] = (i < width) && (i >= trunc);
        end
        return m;
    endfunction

endpackage

// File: rtl/acca_pp.sv
// One half-width quadrant partial product, producing both the exact value and
// the low-bit truncated approximation.
module acca_pp
    import acca_pkg::*;
#(
    parameter int H     = 4,
    parameter int TRUNC = 2
) (
    input  logic [H-1:0]   x,
    input  logic [H-1:0]   y,
    input  logic           approx,
    output logic [2*H-1:0] exact,
    output logic [2*H-1:0] prod
);

    localparam logic [MASK_MAX-1:0] MASK_FULL = truncMask(2 * H, TRUNC);
    localparam logic [2*H-1:0]      MASK      = MASK_FULL[2*H-1:0];

    logic [2*H-1:0] xWide;
    logic [2*H-1:0] yWide;

    assign xWide = {{H{1'b0}}, x};
    assign yWide = {{H{1'b0}}, y};
    assign exact = xWide * yWide;
    assign prod  = approx ? (exact & MASK) : exact;

endmodule

// File: rtl/acca_mul_pipe.sv
// Three-stage valid/ready pipelined approximate multiplier with per-quadrant
// exact/truncated selection and an exact-minus-approximate error output.
module acca_mul_pipe
    import acca_pkg::*;
#(
    parameter int         W          = 8,
    parameter int         TRUNC      = 2,
    parameter logic [3:0] RESET_MODE = 4'b0000
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           cfg_we,
    input  logic [3:0]     cfg_mode,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   in_a,
    input  logic [W-1:0]   in_b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] out_prod,
    output logic [2*W-1:0] out_err,
    output logic [3:0]     mode_q
);

    localparam int H = W / 2;

    logic [3:0]          modeReg_q, modeReg_d;

    logic                s1Valid_q;
    logic [W-1:0]        s1A_q, s1B_q;
    logic [3:0]          s1Mode_q;

    logic [3:0][W-1:0]   ppApprox, ppExact;
    logic                s2Valid_q;
    logic [3:0][W-1:0]   s2Approx_q, s2Exact_q;

    logic [2*W-1:0]      prod_d, err_d, exactSum;
    logic                s3Valid_q;
    logic [2*W-1:0]      s3Prod_q, s3Err_q;

    logic                en;

    // A single enable stalls the whole pipe; bubbles are carried, not squeezed out.
    assign en        = !s3Valid_q || out_ready;
    assign in_ready  = en;
    assign out_valid = s3Valid_q;
    assign out_prod  = s3Prod_q;
    assign out_err   = s3Err_q;
    assign mode_q    = modeReg_q;

    acca_pp #(.H(H), .TRUNC(TRUNC)) uPpLl (
        .x      (s1A_q[H-1:0]),
        .y      (s1B_q[H-1:0]),
        .approx (s1Mode_q[MODE_LL]),
        .exact  (ppExact[MODE_LL]),
        .prod   (ppApprox[MODE_LL])
    );

    acca_pp #(.H(H), .TRUNC(TRUNC)) uPpLh (
        .x      (s1A_q[H-1:0]),
        .y      (s1B_q[W-1:H]),
        .approx (s1Mode_q[MODE_LH]),
        .exact  (ppExact[MODE_LH]),
        .prod   (ppApprox[MODE_LH])
    );

    acca_pp #(.H(H), .TRUNC(TRUNC)) uPpHl (
        .x      (s1A_q[W-1:H]),
        .y      (s1B_q[H-1:0]),
        .approx (s1Mode_q[MODE_HL]),
        .exact  (ppExact[MODE_HL]),
        .prod   (ppApprox[MODE_HL])
    );

    acca_pp #(.H(H), .TRUNC(TRUNC)) uPpHh (
        .x      (s1A_q[W-1:H]),
        .y      (s1B_q[W-1:H]),
        .approx (s1Mode_q[MODE_HH]),
        .exact  (ppExact[MODE_HH]),
        .prod   (ppApprox[MODE_HH])
    );

    // Every term is widened to 2W first, so the sum cannot wrap.
    function automatic logic [2*W-1:0] accumulate(input logic [3:0][W-1:0] pp);
        logic [2*W-1:0] hh, hl, lh, ll;
        hh = {{W{1'b0}}, pp[MODE_HH]};
        hl = {{W{1'b0}}, pp[MODE_HL]};
        lh = {{W{1'b0}}, pp[MODE_LH]};
        ll = {{W{1'b0}}, pp[MODE_LL]};
        return (hh << W) + ((hl + lh) << H) + ll;
    endfunction

    always_comb begin
        modeReg_d = cfg_we ? cfg_mode : modeReg_q;
        prod_d    = accumulate(s2Approx_q);
        exactSum  = accumulate(s2Exact_q);
        err_d     = exactSum - prod_d;
    end

    // S1 snapshots the mode register before any same-cycle write lands.
    always_ff @(posedge clk) begin
        if (rst) begin
            modeReg_q  <= RESET_MODE;
            s1Valid_q  <= 1'b0;
            s1A_q      <= '0;
            s1B_q      <= '0;
            s1Mode_q   <= '0;
            s2Valid_q  <= 1'b0;
            s2Approx_q <= '0;
            s2Exact_q  <= '0;
            s3Valid_q  <= 1'b0;
            s3Prod_q   <= '0;
            s3Err_q    <= '0;
        end else begin
            modeReg_q <= modeReg_d;
            if (en) begin
                s1Valid_q <= in_valid;
                if (in_valid) begin
                    s1A_q    <= in_a;
                    s1B_q    <= in_b;
                    s1Mode_q <= modeReg_q;
                end
                s2Valid_q <= s1Valid_q;
                if (s1Valid_q) begin
                    s2Approx_q <= ppApprox;
                    s2Exact_q  <= ppExact;
                end
                s3Valid_q <= s2Valid_q;
                if (s2Valid_q) begin
                    s3Prod_q <= prod_d;
                    s3Err_q  <= err_d;
                end
            end
        end
    end

endmodule

// File: tb/tb_acca_mul_pipe.sv
// Directed, table-driven bench for acca_mul_pipe at W=8, TRUNC=2 with
// hand-computed products, plus stall, same-cycle config and reset sequences.
module tb_acca_mul_pipe;

    logic        clk;
    logic        rst;
    logic        cfg_we;
    logic [3:0]  cfg_mode;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_a;
    logic [7:0]  in_b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_prod;
    logic [15:0] out_err;
    logic [3:0]  mode_q;

    int applied;
    int miscompares;

    typedef struct {
        logic [3:0]  mode;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] prod;
        logic [15:0] err;
    } vec_t;

    vec_t vecs [12];

    acca_mul_pipe #(.W(8), .TRUNC(2), .RESET_MODE(4'b0000)) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_we    (cfg_we),
        .cfg_mode  (cfg_mode),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_prod  (out_prod),
        .out_err   (out_err),
        .mode_q    (mode_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        applied++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Writes the mode, sends one pair, and counts edges from the accept edge
    // (inclusive) until out_valid is seen.
    task automatic applyStimulus(input logic [3:0] mode, input logic [7:0] a, input logic [7:0] b,
                                 output int lat);
        @(posedge clk); #1;
        cfg_we   = 1'b1;
        cfg_mode = mode;
        @(posedge clk); #1;
        cfg_we   = 1'b0;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        lat = 0;
        while (lat < 10) begin
            @(posedge clk); #1;
            lat++;
            if (lat == 1) in_valid = 1'b0;
            if (out_valid) break;
        end
    endtask

    logic [7:0]  sA   [10];
    logic [7:0]  sB   [10];
    logic [15:0] sExp [10];

    initial begin
        int lat;
        int sent;
        int recv;
        int seen;
        logic [15:0] cfgExpProd [2];
        logic [15:0] cfgExpErr  [2];

        applied     = 0;
        miscompares = 0;

        vecs[0]  = '{4'b0000, 8'hFF, 8'hFF, 16'hFE01, 16'h0000};
        vecs[1]  = '{4'b1111, 8'hFF, 8'hFF, 16'hFCE0, 16'h0121};
        vecs[2]  = '{4'b0001, 8'h0F, 8'h0F, 16'h00E0, 16'h0001};
        vecs[3]  = '{4'b1000, 8'h0F, 8'h0F, 16'h00E1, 16'h0000};
        vecs[4]  = '{4'b0000, 8'h00, 8'h00, 16'h0000, 16'h0000};
        vecs[5]  = '{4'b1111, 8'h12, 8'h34, 16'h0088, 16'h0320};
        vecs[6]  = '{4'b0100, 8'hB5, 8'h3D, 16'h2AF1, 16'h0030};
        vecs[7]  = '{4'b0010, 8'h37, 8'hB2, 16'h262E, 16'h0010};
        vecs[8]  = '{4'b1000, 8'hFF, 8'h10, 16'h0CF0, 16'h0300};
        vecs[9]  = '{4'b0011, 8'h03, 8'hF3, 16'h02C8, 16'h0011};
        vecs[10] = '{4'b1111, 8'h01, 8'h01, 16'h0000, 16'h0001};
        vecs[11] = '{4'b0000, 8'hA5, 8'h5A, 16'h3A02, 16'h0000};

        for (int i = 0; i < 10; i++) begin
            sA[i]   = 8'(i * 23 + 7);
            sB[i]   = 8'(250 - i * 11);
            sExp[i] = 16'(sA[i]) * 16'(sB[i]);
        end

        rst       = 1'b1;
        cfg_we    = 1'b0;
        cfg_mode  = 4'b0000;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b1;

        @(posedge clk); #1;
        @(posedge clk); #1;
        checkOutput("reset_out_valid", out_valid, 1'b0);
        checkOutput("reset_out_prod", out_prod, 16'h0000);
        checkOutput("reset_out_err", out_err, 16'h0000);
        checkOutput("reset_mode_q", mode_q, 4'b0000);
        rst = 1'b0;
        #1;
        checkOutput("reset_in_ready", in_ready, 1'b1);

        $display("[TB] table vectors");
        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i].mode, vecs[i].a, vecs[i].b, lat);
            checkOutput($sformatf("vec%0d_latency", i), lat, 3);
            checkOutput($sformatf("vec%0d_mode_q", i), mode_q, vecs[i].mode);
            checkOutput($sformatf("vec%0d_prod", i), out_prod, vecs[i].prod);
            checkOutput($sformatf("vec%0d_err", i), out_err, vecs[i].err);
        end

        $display("[TB] stream with stall");
        @(posedge clk); #1;
        cfg_we   = 1'b1;
        cfg_mode = 4'b0000;
        @(posedge clk); #1;
        cfg_we = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        sent = 0;
        recv = 0;
        for (int cyc = 0; cyc < 60 && recv < 10; cyc++) begin
            if (cyc != 0) begin
                @(posedge clk); #1;
            end
            out_ready = !(cyc >= 4 && cyc <= 7);
            if (sent < 10) begin
                in_valid = 1'b1;
                in_a     = sA[sent];
                in_b     = sB[sent];
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (cyc >= 4 && cyc <= 7) begin
                checkOutput("stall_in_ready", in_ready, 1'b0);
                checkOutput("stall_out_valid", out_valid, 1'b1);
                checkOutput("stall_prod_held", out_prod, sExp[recv]);
                checkOutput("stall_err_held", out_err, 16'h0000);
            end
            if (in_valid && in_ready) sent++;
            if (out_valid && out_ready) begin
                checkOutput($sformatf("stream%0d_prod", recv), out_prod, sExp[recv]);
                checkOutput($sformatf("stream%0d_err", recv), out_err, 16'h0000);
                recv++;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        checkOutput("stream_sent", sent, 10);
        checkOutput("stream_received", recv, 10);

        $display("[TB] cfg write alongside accepted pair");
        cfgExpProd[0] = 16'hFE01;
        cfgExpErr[0]  = 16'h0000;
        cfgExpProd[1] = 16'hFCE0;
        cfgExpErr[1]  = 16'h0121;
        @(posedge clk); #1;
        @(posedge clk); #1;
        cfg_we   = 1'b1;
        cfg_mode = 4'b1111;
        in_valid = 1'b1;
        in_a     = 8'hFF;
        in_b     = 8'hFF;
        @(posedge clk); #1;
        cfg_we = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        recv = 0;
        for (int cyc = 0; cyc < 10 && recv < 2; cyc++) begin
            @(negedge clk);
            if (out_valid && out_ready) begin
                checkOutput($sformatf("cfg_pair%0d_prod", recv), out_prod, cfgExpProd[recv]);
                checkOutput($sformatf("cfg_pair%0d_err", recv), out_err, cfgExpErr[recv]);
                recv++;
            end
            @(posedge clk); #1;
        end
        checkOutput("cfg_pairs_received", recv, 2);
        checkOutput("cfg_mode_q", mode_q, 4'b1111);

        $display("[TB] reset with results in flight");
        @(posedge clk); #1;
        cfg_we   = 1'b1;
        cfg_mode = 4'b1010;
        @(posedge clk); #1;
        cfg_we = 1'b0;
        checkOutput("pre_reset_mode_q", mode_q, 4'b1010);
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_a     = sA[i];
            in_b     = sB[i];
            @(posedge clk); #1;
        end
        checkOutput("pre_reset_out_valid", out_valid, 1'b1);
        rst      = 1'b1;
        in_a     = 8'hFF;
        in_b     = 8'hFF;
        @(posedge clk); #1;
        checkOutput("post_reset_out_valid", out_valid, 1'b0);
        checkOutput("post_reset_out_prod", out_prod, 16'h0000);
        checkOutput("post_reset_out_err", out_err, 16'h0000);
        checkOutput("post_reset_mode_q", mode_q, 4'b0000);
        checkOutput("post_reset_in_ready", in_ready, 1'b1);
        rst      = 1'b0;
        in_valid = 1'b0;
        seen = 0;
        for (int cyc = 0; cyc < 8; cyc++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        checkOutput("no_stale_results", seen, 0);

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
